unified_mem_arbiter: RTL and testbench
======================================

# unified_mem_arbiter

Arbitrates the single-ported unified instruction/data memory between the pipeline's instruction-fetch stage (I port) and memory stage (D port). Sits between the `processor` pipeline stages and the memory model. Serialises accesses with a request/ready handshake and gives data accesses priority, with a starvation guard for fetch. Supports cancelling an in-flight fetch on a branch flush.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data word width; wstrb width is DATA_WIDTH/8
- STARVE_LIMIT, 4, consecutive D grants allowed while I is pending before I is forced

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- i_req  in  1  fetch request; held with i_addr stable until i_ready
- i_addr  in  ADDR_WIDTH  fetch address
- i_flush  in  1  single-cycle pulse that cancels a pending or in-flight fetch
- i_ready  out  1  single-cycle fetch completion
- i_rdata  out  DATA_WIDTH  fetched word, valid when i_ready
- d_req  in  1  data request; held with address, data, we and wstrb stable until d_ready
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  store data
- d_wstrb  in  DATA_WIDTH/8  byte enables for stores
- d_ready  out  1  single-cycle data completion
- d_rdata  out  DATA_WIDTH  load data, valid when d_ready && !d_we
- mem_req  out  1  memory access active; held until mem_ready
- mem_we, mem_addr, mem_wdata, mem_wstrb  out  1 / ADDR_WIDTH / DATA_WIDTH / DATA_WIDTH/8  registered access fields
- mem_ready  in  1  memory completes the current access this cycle
- mem_rdata  in  DATA_WIDTH  read data, valid with mem_ready

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D. mem_req = (state != IDLE).
- IDLE: if d_req && !(i_pend && starve_cnt == STARVE_LIMIT), go to BUSY_D. Otherwise, if i_pend, go to BUSY_I. i_pend = i_req && !i_flush.
- On grant, latch the mem_* fields from the granted port. mem_we = 0 for fetch; mem_wstrb = 0 for loads and fetches.
- BUSY_x: hold all mem_* outputs. When mem_ready is high, return to IDLE.
- Completion: d_ready = (state == BUSY_D) && mem_ready. i_ready = (state == BUSY_I) && mem_ready && !discard && !i_flush. rdata outputs pass mem_rdata through combinationally.
- discard flag: set by i_flush while in BUSY_I. Cleared on entering IDLE. A discarded fetch still waits for mem_ready, but produces no i_ready.
- starve_cnt:
  - Increments on a D grant when i_pend is high.
  - Clears on an I grant, and on a D grant when i_pend is low.
  - Saturates at STARVE_LIMIT.
- Requester still asserting req in the cycle after ready: treated as a new request.
- Reset: state IDLE, mem_req 0, all mem_* fields 0, discard 0, starve_cnt 0, i_ready and d_ready 0. Reset takes effect immediately, including mid-access. The memory model must tolerate a dropped mem_req.

## Timing
- Grant is registered. Request in IDLE at cycle 0 gives mem_req high at cycle 1.
- Zero-wait memory (mem_ready in cycle 1) gives ready in cycle 1. Latency is 1 + memory wait cycles.
- The completion cycle always returns to IDLE, so the next grant's mem_req rises no earlier than 2 cycles after the previous completion's mem_req rise.
- Peak throughput: one access per 2 cycles.
- Simultaneous i_req and d_req in IDLE: D wins unless starve_cnt == STARVE_LIMIT.
- i_flush in the same cycle as i_req in IDLE: no grant.
- i_flush in the same cycle as mem_ready in BUSY_I: i_ready suppressed.

## Structure
- State encodings and the mem access field widths go in the shared processor definitions package (`processor_pkg`), alongside the pipeline constants.
- One sub-module, `arb_starve_counter`: a saturating counter with inc/clr/full, parameterised by STARVE_LIMIT.
- FSM, latch registers and response gating stay in `unified_mem_arbiter`.

## Test plan
- Single fetch, i_addr=0x40, memory with 2 wait cycles returning 0x00500093 -> mem_req high in cycles 1–3, i_ready pulse in cycle 3 with i_rdata=0x00500093.
- i_req and d_req in the same cycle (load 0x1000) -> D granted first, mem_addr=0x1000. I granted after d_ready, with one IDLE bubble.
- d_req held continuously with i_req pending, STARVE_LIMIT=4 -> exactly 4 D accesses, then 1 I access, then D resumes.
- Store: d_addr=0x2004, d_wdata=0xDEADBEEF, d_wstrb=4'b0011 -> mem_we=1 with identical fields latched. d_ready on mem_ready.
- i_flush mid-fetch, during wait cycle 1 of 3 -> no i_ready. FSM returns to IDLE only on mem_ready. A new fetch to 0x80 is then served normally.
- reset driven low during BUSY_D -> mem_req, d_ready and state clear asynchronously. After release, the bench completes a fresh fetch correctly.

Source files
------------

// File: rtl/processor_pkg.sv
// Shared processor definitions: pipeline constants, memory access field widths
// and the unified memory arbiter state encoding.
package processor_pkg;

  localparam int XLEN       = 32;
  localparam int RESET_PC   = 32'h0000_0000;
  localparam int NUM_STAGES = 5;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_STRB_W = MEM_DATA_W / 8;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2
  } arb_state_e;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive data grants taken while a fetch is waiting.
module arb_starve_counter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic inc_i,
  input  logic clr_i,
  output logic full_o
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && (cnt_q != LIMIT))
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign full_o = (cnt_q == LIMIT);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates the single-ported unified memory between fetch (I) and data (D) ports.
// D has priority; the starvation counter forces an I grant after STARVE_LIMIT D grants.
module unified_mem_arbiter
  import processor_pkg::*;
#(
  parameter int ADDR_WIDTH   = MEM_ADDR_W,
  parameter int DATA_WIDTH   = MEM_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    i_req,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic                    i_flush,
  output logic                    i_ready,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_wstrb,
  output logic                    d_ready,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic                    mem_ready,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  arb_state_e                state_q;
  logic                      mem_we_q;
  logic [ADDR_WIDTH-1:0]     mem_addr_q;
  logic [DATA_WIDTH-1:0]     mem_wdata_q;
  logic [DATA_WIDTH/8-1:0]   mem_wstrb_q;
  logic                      discard_q;

  logic i_pend;
  logic starve_full;
  logic grant_d;
  logic grant_i;

  assign i_pend  = i_req && !i_flush;
  assign grant_d = (state_q == ARB_IDLE) && d_req && !(i_pend && starve_full);
  assign grant_i = (state_q == ARB_IDLE) && !grant_d && i_pend;

  arb_starve_counter #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clock  (clock),
    .reset  (reset),
    .inc_i  (grant_d && i_pend),
    .clr_i  (grant_i || (grant_d && !i_pend)),
    .full_o (starve_full)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ARB_IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      discard_q   <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          discard_q <= 1'b0;
          if (grant_d) begin
            state_q     <= ARB_BUSY_D;
            mem_we_q    <= d_we;
            mem_addr_q  <= d_addr;
            mem_wdata_q <= d_wdata;
            mem_wstrb_q <= d_we ? d_wstrb : '0;
          end else if (grant_i) begin
            state_q     <= ARB_BUSY_I;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= i_addr;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
          end
        end
        // A flushed fetch still has to drain the memory access before IDLE.
        ARB_BUSY_I: begin
          if (mem_ready) begin
            state_q   <= ARB_IDLE;
            discard_q <= 1'b0;
          end else if (i_flush) begin
            discard_q <= 1'b1;
          end
        end
        ARB_BUSY_D: begin
          if (mem_ready)
            state_q <= ARB_IDLE;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign mem_req   = (state_q != ARB_IDLE);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;

  assign d_ready = (state_q == ARB_BUSY_D) && mem_ready;
  assign i_ready = (state_q == ARB_BUSY_I) && mem_ready && !discard_q && !i_flush;
  assign d_rdata = mem_rdata;
  assign i_rdata = mem_rdata;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter with a configurable-wait memory model.
module tb_unified_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_req, i_flush, i_ready;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_ready;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_wstrb;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int total = 0;
  int bad   = 0;
  int mem_wait = 0;
  logic [3:0] wcnt;

  always #5 clock = ~clock;

  unified_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  // Memory model: mem_ready after mem_wait wait cycles; data derived from address.
  always @(posedge clock or negedge reset) begin
    if (!reset) wcnt <= '0;
    else if (mem_req && !mem_ready) wcnt <= wcnt + 4'd1;
    else wcnt <= '0;
  end
  assign mem_ready = mem_req && (wcnt == mem_wait[3:0]);
  assign mem_rdata = (mem_addr == 32'h40) ? 32'h00500093 : (32'hA5A50000 ^ mem_addr);

  task automatic test_reset();
    reset = 1'b0; i_req = 0; i_flush = 0; i_addr = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
    @(negedge clock);
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%0b exp=0", mem_req); end
    total++; if ({mem_we, mem_addr, mem_wdata, mem_wstrb} !== 69'd0) begin bad++; $display("FAIL reset_fields got=%0h exp=0", {mem_we, mem_addr, mem_wdata, mem_wstrb}); end
    total++; if ({i_ready, d_ready} !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b exp=00", {i_ready, d_ready}); end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_single_fetch();
    mem_wait = 2;
    i_req = 1; i_addr = 32'h40;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL fetch_mem_req c%0d got=%0b exp=1", c, mem_req); end
      total++; if (i_ready !== (c == 3)) begin bad++; $display("FAIL fetch_i_ready c%0d got=%0b exp=%0b", c, i_ready, c == 3); end
    end
    total++; if (i_rdata !== 32'h00500093) begin bad++; $display("FAIL fetch_rdata got=%h exp=00500093", i_rdata); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL fetch_we got=%0b exp=0", mem_we); end
    i_req = 0;
    @(negedge clock);
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL fetch_idle got=%0b exp=0", mem_req); end
  endtask

  task automatic test_priority();
    mem_wait = 0;
    d_req = 1; d_we = 0; d_addr = 32'h1000; d_wstrb = 4'hF; d_wdata = 32'h1234;
    i_req = 1; i_addr = 32'h44;
    @(negedge clock);
    total++; if (mem_addr !== 32'h1000) begin bad++; $display("FAIL prio_d_addr got=%h exp=00001000", mem_addr); end
    total++; if (d_ready !== 1'b1 || i_ready !== 1'b0) begin bad++; $display("FAIL prio_d_ready got d=%0b i=%0b exp d=1 i=0", d_ready, i_ready); end
    total++; if (d_rdata !== 32'hA5A51000) begin bad++; $display("FAIL prio_d_rdata got=%h exp=a5a51000", d_rdata); end
    total++; if (mem_wstrb !== 4'h0) begin bad++; $display("FAIL prio_load_wstrb got=%h exp=0", mem_wstrb); end
    d_req = 0;
    @(negedge clock);
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL prio_bubble got=%0b exp=0", mem_req); end
    @(negedge clock);
    total++; if (mem_addr !== 32'h44 || i_ready !== 1'b1) begin bad++; $display("FAIL prio_i_after got addr=%h rdy=%0b exp addr=00000044 rdy=1", mem_addr, i_ready); end
    total++; if (i_rdata !== 32'hA5A50044) begin bad++; $display("FAIL prio_i_rdata got=%h exp=a5a50044", i_rdata); end
    i_req = 0;
    @(negedge clock);
  endtask

  task automatic test_starvation();
    logic [5:0] exp_d;
    exp_d = 6'b101111;  // bit k: access k is a D access
    mem_wait = 0;
    d_req = 1; d_we = 0; d_addr = 32'h3000; d_wstrb = 0;
    i_req = 1; i_addr = 32'h48;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      total++; if (d_ready !== exp_d[k] || i_ready !== !exp_d[k]) begin bad++; $display("FAIL starve_seq k=%0d got d=%0b i=%0b exp d=%0b", k, d_ready, i_ready, exp_d[k]); end
      total++; if (mem_addr !== (exp_d[k] ? 32'h3000 : 32'h48)) begin bad++; $display("FAIL starve_addr k=%0d got=%h", k, mem_addr); end
      if (k == 5) begin d_req = 0; i_req = 0; end
      @(negedge clock);
      total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL starve_bubble k=%0d got=%0b exp=0", k, mem_req); end
    end
  endtask

  task automatic test_store();
    mem_wait = 1;
    d_req = 1; d_we = 1; d_addr = 32'h2004; d_wdata = 32'hDEADBEEF; d_wstrb = 4'b0011;
    @(negedge clock);
    total++; if ({mem_req, mem_we} !== 2'b11) begin bad++; $display("FAIL store_req_we got=%b exp=11", {mem_req, mem_we}); end
    total++; if (mem_addr !== 32'h2004 || mem_wdata !== 32'hDEADBEEF || mem_wstrb !== 4'b0011) begin bad++; $display("FAIL store_fields got=%h/%h/%b", mem_addr, mem_wdata, mem_wstrb); end
    total++; if (d_ready !== 1'b0) begin bad++; $display("FAIL store_early_ready got=%0b exp=0", d_ready); end
    @(negedge clock);
    total++; if (d_ready !== 1'b1 || mem_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL store_ready got rdy=%0b wdata=%h", d_ready, mem_wdata); end
    d_req = 0; d_we = 0; d_wstrb = 0;
    @(negedge clock);
  endtask

  task automatic test_flush();
    // flush together with request in IDLE: no grant
    mem_wait = 0;
    i_req = 1; i_addr = 32'h60; i_flush = 1;
    @(negedge clock);
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL flush_idle_nogrant got=%0b exp=0", mem_req); end
    i_req = 0; i_flush = 0;
    // flush during wait cycle 1 of 3
    mem_wait = 3;
    i_req = 1; i_addr = 32'h50;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clock);
      i_flush = (c == 1);
      if (c == 1) i_req = 0;
      #1;
      total++; if (mem_req !== 1'b1 || i_ready !== 1'b0) begin bad++; $display("FAIL flush_mid c%0d got req=%0b rdy=%0b exp req=1 rdy=0", c, mem_req, i_ready); end
    end
    @(negedge clock);
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL flush_drain got=%0b exp=0", mem_req); end
    // flush in the completion cycle
    mem_wait = 1;
    i_req = 1; i_addr = 32'h54;
    @(negedge clock);
    @(negedge clock);
    i_flush = 1; i_req = 0;
    #1;
    total++; if (mem_ready !== 1'b1 || i_ready !== 1'b0) begin bad++; $display("FAIL flush_at_ready got mrdy=%0b rdy=%0b exp mrdy=1 rdy=0", mem_ready, i_ready); end
    @(negedge clock);
    i_flush = 0;
    // fresh fetch afterwards
    mem_wait = 0;
    i_req = 1; i_addr = 32'h80;
    @(negedge clock);
    total++; if (i_ready !== 1'b1 || i_rdata !== 32'hA5A50080) begin bad++; $display("FAIL flush_refetch got rdy=%0b data=%h exp rdy=1 data=a5a50080", i_ready, i_rdata); end
    i_req = 0;
    @(negedge clock);
  endtask

  task automatic test_reset_mid_access();
    mem_wait = 3;
    d_req = 1; d_we = 0; d_addr = 32'h3000;
    @(negedge clock);
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rst_pre_req got=%0b exp=1", mem_req); end
    @(negedge clock);
    reset = 0;
    #1;
    total++; if ({mem_req, d_ready} !== 2'b00) begin bad++; $display("FAIL rst_async got req/rdy=%b exp=00", {mem_req, d_ready}); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL rst_async_addr got=%h exp=0", mem_addr); end
    d_req = 0;
    @(negedge clock);
    reset = 1;
    @(negedge clock);
    mem_wait = 0;
    i_req = 1; i_addr = 32'h40;
    @(negedge clock);
    total++; if (i_ready !== 1'b1 || i_rdata !== 32'h00500093) begin bad++; $display("FAIL rst_refetch got rdy=%0b data=%h exp rdy=1 data=00500093", i_ready, i_rdata); end
    i_req = 0;
    @(negedge clock);
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_final_idle got=%0b exp=0", mem_req); end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_priority();
    test_starvation();
    test_store();
    test_flush();
    test_reset_mid_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
